// File: rtl/alu_pipe_pkg.sv
// alu_pkg: shared types and constants for the alu_pipe block.
//   op_t    : 4-bit operation codes (1010..1111 are reserved)
//   state_t : control FSM states
//   FLAG_*  : bit positions of {N,Z,C,V} in the flags vector
// Optional feature macro used by the block: ALU_PIPE_MUL_EN.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_XOR = 4'b0010,
      OP_ADD = 4'b0011,
      OP_SUB = 4'b0100,
      OP_LSR = 4'b0101,
      OP_LSL = 4'b0110,
      OP_ASR = 4'b0111,
      OP_NOT = 4'b1000,
      OP_MUL = 4'b1001
   } op_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   localparam int unsigned FLAG_N = 32'd3;
   localparam int unsigned FLAG_Z = 32'd2;
   localparam int unsigned FLAG_C = 32'd1;
   localparam int unsigned FLAG_V = 32'd0;

   localparam logic [3:0] OP_RESERVED_MIN = 4'b1010;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle of the pipelined ALU.
//   in_valid/in_ready   : operation request handshake (upstream -> ALU)
//   op, a, b            : opcode and operands
//   out_valid/out_ready : result handshake (ALU -> writeback)
//   result, flags       : registered result and {N,Z,C,V}
//   illegal             : reserved opcode indicator, valid with out_valid
//   busy                : multiply in progress
// Modports: master = upstream/consumer side, slave = ALU side.
interface alu_pipe_if #(
   parameter int N   = 32,
   parameter int SHW = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic [3:0]   flags;
   logic         illegal;
   logic         busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flags, illegal, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flags, illegal, busy
   );
endinterface

// File: rtl/alu_pipe_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, reset : clock and asynchronous active-high reset
//   start      : capture a/b and clear the accumulator
//   a, b       : multiplicand / multiplier
//   done       : combinational, high during the final step cycle
//   product    : combinational, accumulator value after the current step
//                (low N bits of a*b when done is high)
module alu_mul_iter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         done,
   output logic [N-1:0] product
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  mcand_r;
   logic [N-1:0]  mplier_r;
   logic [N-1:0]  acc_r;
   logic [CW-1:0] cnt_r;
   logic          active_r;
   logic [N-1:0]  acc_next_s;

   // Multiplicand is pre-shifted each step, so only mplier bit 0 is inspected.
   assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {N{1'b0}});
   assign done       = active_r && (cnt_r == CW'(N - 1));
   assign product    = acc_next_s;

   // Operand capture and one shift-add step per cycle while active.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         cnt_r    <= '0;
         active_r <= 1'b0;
      end else if (start) begin
         mcand_r  <= a;
         mplier_r <= b;
         acc_r    <= '0;
         cnt_r    <= '0;
         active_r <= 1'b1;
      end else if (active_r) begin
         acc_r    <= acc_next_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         cnt_r    <= cnt_r + CW'(1);
         if (cnt_r == CW'(N - 1)) begin
            active_r <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with NZCV flags.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : alu_pipe_if.slave (request, result and status signals)
// Single-cycle ops register their result one edge after acceptance.
// With macro ALU_PIPE_MUL_EN defined, opcode MUL runs an N-cycle iterative
// multiply that stalls the input side; otherwise MUL is treated as reserved.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int N   = 32,
   parameter int SHW = 8
) (
   input logic        clk,
   input logic        reset,
   alu_pipe_if.slave  bus
);
   state_t         state_r;
   logic           out_valid_r;
   logic [N-1:0]   result_r;
   logic [3:0]     flags_r;
   logic           illegal_r;
   logic           busy_r;

   logic           in_ready_s;
   logic           accept_s;
   logic           is_mul_s;
   logic [SHW-1:0] amt_s;
   logic [N:0]     sum_s;
   logic [N:0]     diff_s;
   logic [N:0]     lsr_ext_s;
   logic [N:0]     lsl_ext_s;
   logic signed [N:0] asr_ext_s;
   logic [N-1:0]   res_s;
   logic           c_s;
   logic           v_s;
   logic           ill_s;
   logic [3:0]     flg_s;
   logic           mul_done_s;
   logic [N-1:0]   mul_product_s;
   logic [3:0]     mul_flags_s;

   assign in_ready_s = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.flags     = flags_r;
   assign bus.illegal   = illegal_r;
   assign bus.busy      = busy_r;

`ifdef ALU_PIPE_MUL_EN
   assign is_mul_s = (bus.op == OP_MUL);

   alu_mul_iter #(.N(N)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept_s && is_mul_s),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done_s),
      .product (mul_product_s)
   );
`else
   assign is_mul_s      = 1'b0;
   assign mul_done_s    = 1'b0;
   assign mul_product_s = '0;
`endif

   // Shifts are done one bit wider so the last bit shifted out lands in the
   // extra position; this yields the carry for every amount, including 0
   // (carry 0), == N and > N, without separate range checks.
   assign amt_s     = bus.b[SHW-1:0];
   assign sum_s     = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff_s    = {1'b0, bus.a} - {1'b0, bus.b};
   assign lsr_ext_s = {bus.a, 1'b0} >> amt_s;
   assign lsl_ext_s = {1'b0, bus.a} << amt_s;
   assign asr_ext_s = $signed({bus.a, 1'b0}) >>> amt_s;

   // Single-cycle datapath: result, carry, overflow and reserved decode.
   always_comb begin
      res_s = '0;
      c_s   = 1'b0;
      v_s   = 1'b0;
      ill_s = 1'b0;
      case (bus.op)
         OP_AND: res_s = bus.a & bus.b;
         OP_OR:  res_s = bus.a | bus.b;
         OP_XOR: res_s = bus.a ^ bus.b;
         OP_ADD: begin
            res_s = sum_s[N-1:0];
            c_s   = sum_s[N];
            v_s   = (bus.a[N-1] == bus.b[N-1]) && (sum_s[N-1] != bus.a[N-1]);
         end
         OP_SUB: begin
            res_s = diff_s[N-1:0];
            c_s   = ~diff_s[N];
            v_s   = (bus.a[N-1] != bus.b[N-1]) && (diff_s[N-1] != bus.a[N-1]);
         end
         OP_LSR: begin
            res_s = lsr_ext_s[N:1];
            c_s   = lsr_ext_s[0];
         end
         OP_LSL: begin
            res_s = lsl_ext_s[N-1:0];
            c_s   = lsl_ext_s[N];
         end
         OP_ASR: begin
            res_s = asr_ext_s[N:1];
            c_s   = asr_ext_s[0];
         end
         OP_NOT: res_s = ~bus.b;
         // Reserved codes, and MUL when the multiplier is not built. In the
         // MUL build an accepted MUL takes the iterative path instead.
         default: ill_s = 1'b1;
      endcase
   end

   // Flag assembly; reserved opcodes report all-zero flags.
   always_comb begin
      flg_s = 4'b0000;
      if (ill_s) begin
         flg_s = 4'b0000;
      end else begin
         flg_s[FLAG_N] = res_s[N-1];
         flg_s[FLAG_Z] = (res_s == '0);
         flg_s[FLAG_C] = c_s;
         flg_s[FLAG_V] = v_s;
      end
   end

   // Multiply flags: only N and Z are meaningful.
   always_comb begin
      mul_flags_s         = 4'b0000;
      mul_flags_s[FLAG_N] = mul_product_s[N-1];
      mul_flags_s[FLAG_Z] = (mul_product_s == '0);
   end

   // Control FSM and registered output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         flags_r     <= 4'b0000;
         illegal_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  if (is_mul_s) begin
                     // Output is empty or draining this cycle (in_ready held).
                     state_r     <= MUL;
                     busy_r      <= 1'b1;
                     out_valid_r <= 1'b0;
                  end else begin
                     result_r    <= res_s;
                     flags_r     <= flg_s;
                     illegal_r   <= ill_s;
                     out_valid_r <= 1'b1;
                  end
               end else if (out_valid_r && bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            MUL: begin
               if (mul_done_s) begin
                  result_r    <= mul_product_s;
                  flags_r     <= mul_flags_s;
                  illegal_r   <= 1'b0;
                  out_valid_r <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule
